k285_sync_controller: RTL and testbench

Symbol-lock controller for the serial 8b/10b receive path. It consumes the per-bit comma flag from the K28.5 detector and a code-error flag from the downstream decoder. It runs a three-comma acquisition / error-budget loss state machine and owns the 10-bit symbol framing counter. It drives the symbol-strobe (`lectura`) and lock status that gate the deserializer and decoder.

---
 rtl/k285_sync_controller.sv | 146 ++++++++++++++
 tb/tb_k285_sync_controller.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/k285_sync_controller.sv
// rtl/k285_sync_controller.sv - 8b/10b symbol-lock controller: comma acquisition, error-budget loss, symbol framing.
module k285_sync_controller #(
    parameter int SYMBOL_BITS      = 10,
    parameter int COMMAS_TO_LOCK   = 3,
    parameter int ERRORS_TO_UNLOCK = 4,
    parameter int GOOD_TO_FORGIVE  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enb,
    input  logic       esk285,
    input  logic       codeErr,
    output logic       lectura,
    output logic       sincronizado,
    output logic [2:0] estado,
    output logic [2:0] errCnt
);

    localparam int BW = (SYMBOL_BITS > 1) ? $clog2(SYMBOL_BITS) : 1;
    localparam logic [BW-1:0] BIT_LAST    = BW'(SYMBOL_BITS - 1);
    localparam logic [2:0]    COMMA_LOCK  = 3'(COMMAS_TO_LOCK);
    localparam logic [2:0]    ERR_UNLOCK  = 3'(ERRORS_TO_UNLOCK);
    localparam logic [2:0]    GOOD_FORGIVE = 3'(GOOD_TO_FORGIVE);

    typedef enum logic [2:0] {
        LOSS    = 3'd0,
        ACQUIRE = 3'd1,
        SYNC    = 3'd2
    } state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] bit_cnt, bit_cnt_d;
    logic [2:0]    comma_cnt, comma_cnt_d;
    logic [2:0]    good_cnt, good_cnt_d;
    logic [2:0]    err_cnt, err_cnt_d;
    logic          at_last;
    logic          misaligned;
    logic          bad_sym;
    logic          lectura_d;
    logic [2:0]    comma_inc, good_inc, err_inc;

    // at_last is the boundary position; enb gating is applied at the register update
    assign at_last    = (bit_cnt == BIT_LAST);
    assign misaligned = esk285 && !at_last;
    assign bad_sym    = (at_last && codeErr) || misaligned;
    assign comma_inc  = comma_cnt + 3'd1;
    assign good_inc   = good_cnt + 3'd1;
    assign err_inc    = err_cnt + 3'd1;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = at_last ? '0 : bit_cnt + BW'(1);
        comma_cnt_d = comma_cnt;
        good_cnt_d  = good_cnt;
        err_cnt_d   = err_cnt;

        case (state_q)
            LOSS: begin
                comma_cnt_d = '0;
                good_cnt_d  = '0;
                err_cnt_d   = '0;
                if (esk285) begin
                    bit_cnt_d   = '0;
                    comma_cnt_d = 3'd1;
                    state_d     = ACQUIRE;
                end
            end

            ACQUIRE: begin
                if (misaligned) begin
                    bit_cnt_d   = '0;
                    comma_cnt_d = 3'd1;
                end else if (at_last && codeErr) begin
                    state_d     = LOSS;
                    comma_cnt_d = '0;
                    good_cnt_d  = '0;
                    err_cnt_d   = '0;
                end else if (at_last && esk285) begin
                    comma_cnt_d = comma_inc;
                    if (comma_inc == COMMA_LOCK) begin
                        state_d    = SYNC;
                        good_cnt_d = '0;
                        err_cnt_d  = '0;
                    end
                end
            end

            SYNC: begin
                // framing is frozen here: a stray comma is charged as an error, never realigned
                if (bad_sym) begin
                    if (err_inc == ERR_UNLOCK) begin
                        state_d     = LOSS;
                        comma_cnt_d = '0;
                        good_cnt_d  = '0;
                        err_cnt_d   = '0;
                    end else begin
                        err_cnt_d  = err_inc;
                        good_cnt_d = '0;
                    end
                end else if (at_last) begin
                    if (good_inc == GOOD_FORGIVE) begin
                        good_cnt_d = '0;
                        err_cnt_d  = (err_cnt != 3'd0) ? err_cnt - 3'd1 : 3'd0;
                    end else begin
                        good_cnt_d = good_inc;
                    end
                end
            end

            default: begin
                state_d     = LOSS;
                comma_cnt_d = '0;
                good_cnt_d  = '0;
                err_cnt_d   = '0;
            end
        endcase
    end

    assign lectura_d = enb && at_last && (state_d == SYNC);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= LOSS;
            bit_cnt      <= '0;
            comma_cnt    <= '0;
            good_cnt     <= '0;
            err_cnt      <= '0;
            lectura      <= 1'b0;
            sincronizado <= 1'b0;
        end else begin
            lectura <= lectura_d;
            if (enb) begin
                state_q      <= state_d;
                bit_cnt      <= bit_cnt_d;
                comma_cnt    <= comma_cnt_d;
                good_cnt     <= good_cnt_d;
                err_cnt      <= err_cnt_d;
                sincronizado <= (state_d == SYNC);
            end
        end
    end

    assign estado = state_q;
    assign errCnt = err_cnt;

endmodule

// File: tb/tb_k285_sync_controller.sv
// tb/tb_k285_sync_controller.sv - directed scoreboard bench for k285_sync_controller.
module tb_k285_sync_controller;

    localparam logic [9:0] K_P = 10'b0011111010;
    localparam logic [9:0] K_N = 10'b1100000101;
    localparam logic [9:0] DAT = 10'b1010101010;

    logic       clk = 1'b0;
    logic       rst, enb, esk285, codeErr;
    logic       lectura, sincronizado;
    logic [2:0] estado, errCnt;

    k285_sync_controller dut (
        .clk(clk), .rst(rst), .enb(enb), .esk285(esk285), .codeErr(codeErr),
        .lectura(lectura), .sincronizado(sincronizado), .estado(estado), .errCnt(errCnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       lec;
        logic       syn;
        logic [2:0] est;
        logic [2:0] err;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_fail = 0;
    int   lec_cnt = 0;
    logic [9:0] sh = '0;

    // reference model
    int m_st = 0, m_bit = 0, m_comma = 0, m_good = 0, m_err = 0;
    logic m_lec = 1'b0;

    task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_bit = 0; m_comma = 0; m_good = 0; m_err = 0; m_lec = 1'b0;
    endtask

    task automatic model_edge(input logic e, input logic k, input logic c);
        int  nbit;
        logic bnd;
        if (!e) begin
            m_lec = 1'b0;
            return;
        end
        bnd  = (m_bit == 9);
        nbit = bnd ? 0 : m_bit + 1;
        if (m_st == 0) begin
            if (k) begin nbit = 0; m_comma = 1; m_st = 1; end
            else begin m_comma = 0; m_err = 0; m_good = 0; end
        end else if (m_st == 1) begin
            if (k && !bnd) begin nbit = 0; m_comma = 1; end
            else if (bnd && c) begin m_st = 0; m_comma = 0; m_err = 0; m_good = 0; end
            else if (bnd && k) begin
                m_comma++;
                if (m_comma == 3) begin m_st = 2; m_err = 0; m_good = 0; end
            end
        end else begin
            if ((bnd && c) || (k && !bnd)) begin
                if (m_err + 1 == 4) begin m_st = 0; m_comma = 0; m_err = 0; m_good = 0; end
                else begin m_err++; m_good = 0; end
            end else if (bnd) begin
                m_good++;
                if (m_good == 4) begin m_good = 0; if (m_err > 0) m_err--; end
            end
        end
        m_bit = nbit;
        m_lec = bnd && (m_st == 2);
    endtask

    task automatic step(input logic e, input logic k, input logic c);
        exp_t x;
        enb = e; esk285 = k; codeErr = c;
        model_edge(e, k, c);
        sb.push_back('{lec: m_lec, syn: (m_st == 2), est: 3'(m_st), err: 3'(m_err)});
        @(posedge clk);
        #1;
        x = sb.pop_front();
        chk("lectura", {2'b0, lectura}, {2'b0, x.lec});
        chk("sincronizado", {2'b0, sincronizado}, {2'b0, x.syn});
        chk("estado", estado, x.est);
        chk("errCnt", errCnt, x.err);
        if (lectura) lec_cnt++;
    endtask

    task automatic send_bit(input logic b, input logic c);
        sh = {sh[8:0], b};
        step(1'b1, (sh == K_P) || (sh == K_N), c);
    endtask

    task automatic send_sym(input logic [9:0] w, input logic c);
        for (int i = 9; i >= 0; i--) send_bit(w[i], (i == 0) ? c : 1'b0);
    endtask

    task automatic send_bits(input logic [15:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(v[i], 1'b0);
    endtask

    initial begin
        rst = 1'b1; enb = 1'b0; esk285 = 1'b0; codeErr = 1'b0;
        #3;
        chk("rst_estado", estado, 3'd0);
        chk("rst_sinc", {2'b0, sincronizado}, 3'd0);
        chk("rst_lectura", {2'b0, lectura}, 3'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();

        // three back-to-back commas lock
        send_sym(K_P, 1'b0);
        chk("acq_after_c1", estado, 3'd1);
        send_sym(K_P, 1'b0);
        chk("acq_after_c2", estado, 3'd1);
        send_sym(K_P, 1'b0);
        chk("lock_estado", estado, 3'd2);
        chk("lock_sinc", {2'b0, sincronizado}, 3'd1);
        chk("lock_lectura", {2'b0, lectura}, 3'd1);
        lec_cnt = 0;
        send_sym(DAT, 1'b0);
        send_sym(DAT, 1'b0);
        chk("lectura_period", 3'(lec_cnt), 3'd2);

        // four consecutive errors drop lock
        send_sym(DAT, 1'b1); chk("err1", errCnt, 3'd1);
        send_sym(DAT, 1'b1); chk("err2", errCnt, 3'd2);
        send_sym(DAT, 1'b1); chk("err3", errCnt, 3'd3);
        send_sym(DAT, 1'b1);
        chk("unlock_estado", estado, 3'd0);
        chk("unlock_err", errCnt, 3'd0);
        chk("unlock_lectura", {2'b0, lectura}, 3'd0);
        lec_cnt = 0;
        send_sym(DAT, 1'b0);
        send_sym(DAT, 1'b0);
        chk("no_lectura_loss", 3'(lec_cnt), 3'd0);

        // relock, then errors forgiven by 4 good symbols
        repeat (3) send_sym(K_N, 1'b0);
        chk("relock", estado, 3'd2);
        for (int r = 0; r < 3; r++) begin
            send_sym(DAT, 1'b1);
            chk("forgive_err", errCnt, 3'd1);
            repeat (4) send_sym(DAT, 1'b0);
            chk("forgive_clear", errCnt, 3'd0);
            chk("forgive_hold", estado, 3'd2);
        end

        // misaligned comma while locked: error, no realign
        lec_cnt = 0;
        send_bits(16'b101, 3);
        send_sym(K_P, 1'b0);
        chk("misalign_err", errCnt, 3'd1);
        send_bits(16'b1010101, 7);
        chk("misalign_phase", {2'b0, lectura}, 3'd1);
        chk("misalign_count", 3'(lec_cnt), 3'd2);
        chk("misalign_state", estado, 3'd2);

        // enb low for 7 cycles mid-symbol
        send_bits(16'b1010, 4);
        lec_cnt = 0;
        repeat (7) step(1'b0, 1'b1, 1'b1);
        chk("enb_lectura", 3'(lec_cnt), 3'd0);
        chk("enb_state", estado, 3'd2);
        chk("enb_err", errCnt, 3'd1);
        send_bits(16'b101010, 6);
        chk("enb_phase", {2'b0, lectura}, 3'd1);
        chk("enb_count", 3'(lec_cnt), 3'd1);

        // async reset while locked
        rst = 1'b1;
        #1;
        chk("arst_estado", estado, 3'd0);
        chk("arst_sinc", {2'b0, sincronizado}, 3'd0);
        chk("arst_err", errCnt, 3'd0);
        chk("arst_lectura", {2'b0, lectura}, 3'd0);
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        send_sym(DAT, 1'b0);
        chk("post_rst_loss", estado, 3'd0);

        // code error during acquisition
        send_sym(K_P, 1'b0);
        chk("acq_enter", estado, 3'd1);
        send_sym(DAT, 1'b1);
        chk("acq_err_loss", estado, 3'd0);

        // realign in acquisition restarts the comma count
        send_sym(K_P, 1'b0);
        send_sym(K_P, 1'b0);
        chk("realign_pre", estado, 3'd1);
        send_bits(16'b101, 3);
        send_sym(K_P, 1'b0);
        chk("realign_acq", estado, 3'd1);
        send_sym(K_P, 1'b0);
        chk("realign_c2", estado, 3'd1);
        send_sym(K_P, 1'b0);
        chk("realign_lock", estado, 3'd2);
        chk("realign_lectura", {2'b0, lectura}, 3'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
